// File: rtl/wifi_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wifi_tx_pkg
//  Purpose  : Shared definitions for the 802.11a transmit chain.
//             - RATE codes and their data-bits-per-OFDM-symbol (N_DBPS) values
//             - SERVICE / TAIL field lengths
//             - DATA-field sequencer state encoding
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package wifi_tx_pkg;

    // DATA-field framing lengths, in bits
    localparam int c_svc_bits  = 16;
    localparam int c_tail_bits = 6;

    // RATE codes (R1..R4 as transmitted in the SIGNAL field)
    localparam logic [3:0] c_rate_6m  = 4'b1101;
    localparam logic [3:0] c_rate_9m  = 4'b1111;
    localparam logic [3:0] c_rate_12m = 4'b0101;
    localparam logic [3:0] c_rate_18m = 4'b0111;
    localparam logic [3:0] c_rate_24m = 4'b1001;
    localparam logic [3:0] c_rate_36m = 4'b1011;
    localparam logic [3:0] c_rate_48m = 4'b0001;
    localparam logic [3:0] c_rate_54m = 4'b0011;

    // Data bits per OFDM symbol for each rate
    localparam logic [7:0] c_dbps_6m  = 8'd24;
    localparam logic [7:0] c_dbps_9m  = 8'd36;
    localparam logic [7:0] c_dbps_12m = 8'd48;
    localparam logic [7:0] c_dbps_18m = 8'd72;
    localparam logic [7:0] c_dbps_24m = 8'd96;
    localparam logic [7:0] c_dbps_36m = 8'd144;
    localparam logic [7:0] c_dbps_48m = 8'd192;
    localparam logic [7:0] c_dbps_54m = 8'd216;

    // DATA-field sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SERVICE = 3'd1,
        ST_DATA    = 3'd2,
        ST_TAIL    = 3'd3,
        ST_PAD     = 3'd4,
        ST_DONE    = 3'd5
    } tx_state_e;

endpackage : wifi_tx_pkg
`default_nettype wire

// File: rtl/rate_dbps_lut.sv
`default_nettype none
// ============================================================================
//  Module   : rate_dbps_lut
//  Purpose  : Combinational RATE code -> N_DBPS decode with validity flag.
//             Shared with the SIGNAL-field builder.
//  Ports    : rate   in  4  802.11a RATE code
//             n_dbps out 8  data bits per OFDM symbol (0 when invalid)
//             valid  out 1  rate code is one of the eight legal codes
//  Revision : 1.0  initial release
// ============================================================================
module rate_dbps_lut
    import wifi_tx_pkg::*;
(
    input  logic [3:0] rate,
    output logic [7:0] n_dbps,
    output logic       valid
);

    always_comb begin
        n_dbps = 8'd0;
        valid  = 1'b1;
        case (rate)
            c_rate_6m:  n_dbps = c_dbps_6m;
            c_rate_9m:  n_dbps = c_dbps_9m;
            c_rate_12m: n_dbps = c_dbps_12m;
            c_rate_18m: n_dbps = c_dbps_18m;
            c_rate_24m: n_dbps = c_dbps_24m;
            c_rate_36m: n_dbps = c_dbps_36m;
            c_rate_48m: n_dbps = c_dbps_48m;
            c_rate_54m: n_dbps = c_dbps_54m;
            default:    valid  = 1'b0;
        endcase
    end

endmodule : rate_dbps_lut
`default_nettype wire

// File: rtl/tx_encode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tx_encode_ctrl
//  Purpose  : 802.11a DATA-field frame sequencer in front of the scrambler and
//             convolutional encoder. Serialises SERVICE(16 zeros), the PSDU
//             (LSB first), TAIL(6 zeros) and PAD zeros up to a whole number of
//             OFDM symbols, one bit per cycle.
//  Ports    : Clk        in   1      system clock, rising edge
//             Reset      in   1      asynchronous active-low reset
//             Tx_Req     in   1      frame request (sampled in IDLE only)
//             Rate       in   4      RATE code, sampled with Tx_Req
//             Length     in   LEN_W  PSDU length in bytes, sampled with Tx_Req
//             Tx_Ack     out  1      pulse: request accepted
//             Byte_In    in   8      PSDU byte
//             Byte_Valid in   1      Byte_In valid
//             Byte_Ready out  1      pulse: byte consumed this cycle
//             Bit_Out    out  1      serial bit to scrambler
//             Bit_Valid  out  1      Bit_Out valid / encoder Start
//             Tail_Zero  out  1      tail bit: scrambled bit forced to 0
//             Scr_Init   out  1      pulse: scrambler seed load
//             Sym_Start  out  1      first valid bit of an OFDM symbol
//             Sym_Cnt    out  11     symbols started in the current frame
//             Busy       out  1      frame in progress
//             Done       out  1      pulse after the last pad bit
//             Err        out  1      pulse: request rejected
//  Revision : 1.0  initial release
// ============================================================================
module tx_encode_ctrl
    import wifi_tx_pkg::*;
#(
    parameter int LEN_W     = 12,
    parameter int SVC_BITS  = c_svc_bits,
    parameter int TAIL_BITS = c_tail_bits
)(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Tx_Req,
    input  logic [3:0]       Rate,
    input  logic [LEN_W-1:0] Length,
    output logic             Tx_Ack,
    input  logic [7:0]       Byte_In,
    input  logic             Byte_Valid,
    output logic             Byte_Ready,
    output logic             Bit_Out,
    output logic             Bit_Valid,
    output logic             Tail_Zero,
    output logic             Scr_Init,
    output logic             Sym_Start,
    output logic [10:0]      Sym_Cnt,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    // One counter serves both the SERVICE and the TAIL phase
    localparam int c_ph_max = (SVC_BITS > TAIL_BITS) ? SVC_BITS : TAIL_BITS;
    localparam int c_ph_w   = $clog2(c_ph_max + 1);
    localparam logic [c_ph_w-1:0] c_svc_last  = c_ph_w'(SVC_BITS - 1);
    localparam logic [c_ph_w-1:0] c_tail_last = c_ph_w'(TAIL_BITS - 1);

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;

    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_byte_cnt;     // bytes loaded so far
    logic [7:0]         r_ndbps;
    logic [c_ph_w-1:0]  r_phase_cnt;
    logic [7:0]         r_byte;
    logic               r_full;         // r_byte holds bits still to emit
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_sym_bit_cnt;
    logic [10:0]        r_sym_cnt;
    logic               r_tx_ack;
    logic               r_scr_init;
    logic               r_err;

    logic [7:0]         w_ndbps;
    logic               w_rate_ok;
    logic               w_req_ok;
    logic               w_in_data;
    logic               w_byte_last_bit;
    logic               w_more_bytes;
    logic               w_load;
    logic               w_sym_end;
    logic               w_bit_valid;
    logic               w_tail_zero;
    logic               w_busy;
    logic               w_done;

    rate_dbps_lut u_rate_lut (
        .rate   (Rate),
        .n_dbps (w_ndbps),
        .valid  (w_rate_ok)
    );

    assign w_req_ok        = w_rate_ok && (Length != '0);
    assign w_in_data       = (r_state == ST_DATA);
    assign w_byte_last_bit = r_full && (r_bit_idx == 3'd7);
    assign w_more_bytes    = (r_byte_cnt != r_len);
    // A new byte may enter while the previous one emits b7, keeping the
    // serial stream gapless when the source keeps up.
    assign w_load          = w_in_data && w_more_bytes && Byte_Valid &&
                             (!r_full || w_byte_last_bit);
    assign w_sym_end       = (r_sym_bit_cnt == (r_ndbps - 8'd1));

    // ------------------------------------------------------------------
    // Next state and per-state outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_bit_valid = 1'b0;
        w_tail_zero = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Tx_Req && w_req_ok) w_state_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
                w_bit_valid = 1'b1;
                w_busy      = 1'b1;
                if (r_phase_cnt == c_svc_last) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_bit_valid = r_full;
                w_busy      = 1'b1;
                if (w_byte_last_bit && !w_more_bytes) w_state_nxt = ST_TAIL;
            end
            ST_TAIL: begin
                w_bit_valid = 1'b1;
                w_tail_zero = 1'b1;
                w_busy      = 1'b1;
                if (r_phase_cnt == c_tail_last)
                    w_state_nxt = w_sym_end ? ST_DONE : ST_PAD;
            end
            ST_PAD: begin
                w_bit_valid = 1'b1;
                w_busy      = 1'b1;
                if (w_sym_end) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, phase/byte/symbol counters, pulses
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_len         <= '0;
            r_byte_cnt    <= '0;
            r_ndbps       <= 8'd0;
            r_phase_cnt   <= '0;
            r_byte        <= 8'd0;
            r_full        <= 1'b0;
            r_bit_idx     <= 3'd0;
            r_sym_bit_cnt <= 8'd0;
            r_sym_cnt     <= 11'd0;
            r_tx_ack      <= 1'b0;
            r_scr_init    <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_tx_ack   <= 1'b0;
            r_scr_init <= 1'b0;
            r_err      <= 1'b0;

            if (r_state == ST_IDLE && Tx_Req) begin
                if (w_req_ok) begin
                    r_tx_ack      <= 1'b1;
                    r_scr_init    <= 1'b1;
                    r_len         <= Length;
                    r_ndbps       <= w_ndbps;
                    r_byte_cnt    <= '0;
                    r_phase_cnt   <= '0;
                    r_full        <= 1'b0;
                    r_bit_idx     <= 3'd0;
                    r_sym_bit_cnt <= 8'd0;
                    r_sym_cnt     <= 11'd0;
                end else begin
                    r_err <= 1'b1;
                end
            end

            if (r_state == ST_SERVICE)
                r_phase_cnt <= (r_phase_cnt == c_svc_last) ? '0 : r_phase_cnt + 1'b1;
            else if (r_state == ST_TAIL)
                r_phase_cnt <= (r_phase_cnt == c_tail_last) ? '0 : r_phase_cnt + 1'b1;

            if (w_load) begin
                r_byte     <= Byte_In;
                r_full     <= 1'b1;
                r_bit_idx  <= 3'd0;
                r_byte_cnt <= r_byte_cnt + LEN_W'(1);
            end else if (w_in_data && r_full) begin
                if (r_bit_idx == 3'd7) r_full <= 1'b0;
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            // Symbol counters advance only on valid bits, so stalls hold them
            if (w_bit_valid) begin
                r_sym_bit_cnt <= w_sym_end ? 8'd0 : r_sym_bit_cnt + 8'd1;
                if (r_sym_bit_cnt == 8'd0) r_sym_cnt <= r_sym_cnt + 11'd1;
            end
        end
    end

    assign Tx_Ack     = r_tx_ack;
    assign Scr_Init   = r_scr_init;
    assign Err        = r_err;
    assign Byte_Ready = w_load;
    assign Bit_Valid  = w_bit_valid;
    assign Bit_Out    = w_in_data && r_full && r_byte[r_bit_idx];
    assign Tail_Zero  = w_tail_zero;
    assign Sym_Start  = w_bit_valid && (r_sym_bit_cnt == 8'd0);
    assign Sym_Cnt    = r_sym_cnt;
    assign Busy       = w_busy;
    assign Done       = w_done;

endmodule : tx_encode_ctrl
`default_nettype wire

// File: tb/tb_tx_encode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_encode_ctrl
//  Purpose  : Directed self-checking bench for tx_encode_ctrl.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_tx_encode_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Tx_Req;
    logic [3:0]  Rate;
    logic [11:0] Length;
    logic        Tx_Ack;
    logic [7:0]  Byte_In;
    logic        Byte_Valid;
    logic        Byte_Ready;
    logic        Bit_Out;
    logic        Bit_Valid;
    logic        Tail_Zero;
    logic        Scr_Init;
    logic        Sym_Start;
    logic [10:0] Sym_Cnt;
    logic        Busy;
    logic        Done;
    logic        Err;

    int n_checks = 0;
    int n_errors = 0;

    // byte source / monitor control
    logic a5_mode = 1'b0;
    logic clr     = 1'b0;
    int   byte_idx = 0;

    // monitor results
    int   cnt_bv, cnt_ss, cnt_br, cnt_done, cnt_err, cnt_ack, cnt_scr;
    int   cnt_busy, cnt_gap, cnt_tail, cnt_pad, tail_first, sym_at_done;
    logic bits [0:1023];

    tx_encode_ctrl #(.LEN_W(12), .SVC_BITS(16), .TAIL_BITS(6)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Tx_Req     (Tx_Req),
        .Rate       (Rate),
        .Length     (Length),
        .Tx_Ack     (Tx_Ack),
        .Byte_In    (Byte_In),
        .Byte_Valid (Byte_Valid),
        .Byte_Ready (Byte_Ready),
        .Bit_Out    (Bit_Out),
        .Bit_Valid  (Bit_Valid),
        .Tail_Zero  (Tail_Zero),
        .Scr_Init   (Scr_Init),
        .Sym_Start  (Sym_Start),
        .Sym_Cnt    (Sym_Cnt),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // expected serial bit k of a frame carrying len bytes
    function automatic logic exp_bit(input int k, input int len);
        logic [7:0] b;
        if (k < 16 || k >= 16 + 8 * len) return 1'b0;
        b = a5_mode ? 8'hA5 : pat((k - 16) / 8);
        return b[(k - 16) % 8];
    endfunction

    assign Byte_In = a5_mode ? 8'hA5 : pat(byte_idx);

    always @(posedge Clk) begin
        if (clr)             byte_idx <= 0;
        else if (Byte_Ready) byte_idx <= byte_idx + 1;
    end

    always @(negedge Clk) begin
        if (clr) begin
            cnt_bv = 0; cnt_ss = 0; cnt_br = 0; cnt_done = 0; cnt_err = 0;
            cnt_ack = 0; cnt_scr = 0; cnt_busy = 0; cnt_gap = 0;
            cnt_tail = 0; cnt_pad = 0; tail_first = -1; sym_at_done = -1;
        end else begin
            if (Bit_Valid) begin
                if (cnt_bv < 1024) bits[cnt_bv] = Bit_Out;
                if (Tail_Zero) begin
                    if (cnt_tail == 0) tail_first = cnt_bv;
                    cnt_tail++;
                end else if (cnt_tail != 0) begin
                    cnt_pad++;
                end
                cnt_bv++;
            end
            if (Sym_Start)  cnt_ss++;
            if (Byte_Ready) cnt_br++;
            if (Done) begin cnt_done++; sym_at_done = int'(Sym_Cnt); end
            if (Err)        cnt_err++;
            if (Tx_Ack)     cnt_ack++;
            if (Scr_Init)   cnt_scr++;
            if (Busy) begin
                cnt_busy++;
                if (!Bit_Valid) cnt_gap++;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [3:0] r, input logic [11:0] len);
        @(posedge Clk); #1 clr = 1'b1;
        @(posedge Clk); #1 clr = 1'b0;
        Tx_Req = 1'b1; Rate = r; Length = len;
        @(posedge Clk); #1 Tx_Req = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (cnt_done == 0 && n < 3000) begin
            @(negedge Clk); #1;
            n++;
        end
        chk({nm, "_done_seen"}, (cnt_done != 0) ? 1 : 0, 1);
        repeat (2) @(negedge Clk);
        #1;
    endtask

    task automatic wait_bits(input int target);
        int n = 0;
        while (cnt_bv < target && n < 3000) begin
            @(negedge Clk); #1;
            n++;
        end
        chk("bit_wait", (cnt_bv == target) ? 1 : 0, 1);
    endtask

    task automatic check_frame(input string nm, input int len, input int e_bv,
                               input int e_ss, input int e_pad, input int e_gap);
        int mism = 0;
        chk({nm, "_bits"},       cnt_bv,      e_bv);
        chk({nm, "_sym_start"},  cnt_ss,      e_ss);
        chk({nm, "_sym_cnt"},    sym_at_done, e_ss);
        chk({nm, "_byte_ready"}, cnt_br,      len);
        chk({nm, "_tail_first"}, tail_first,  e_bv - e_pad - 6);
        chk({nm, "_tail_cnt"},   cnt_tail,    6);
        chk({nm, "_pad"},        cnt_pad,     e_pad);
        chk({nm, "_done"},       cnt_done,    1);
        chk({nm, "_ack"},        cnt_ack,     1);
        chk({nm, "_scr_init"},   cnt_scr,     1);
        chk({nm, "_gaps"},       cnt_gap,     e_gap);
        chk({nm, "_busy"},       cnt_busy,    e_bv + e_gap);
        for (int k = 0; k < cnt_bv && k < 1024; k++)
            if (bits[k] !== exp_bit(k, len)) mism++;
        chk({nm, "_seq_mism"}, mism, 0);
    endtask

    task automatic check_reject(input string nm);
        repeat (4) @(negedge Clk);
        #1;
        chk({nm, "_err"},  cnt_err,  1);
        chk({nm, "_ack"},  cnt_ack,  0);
        chk({nm, "_busy"}, cnt_busy, 0);
        chk({nm, "_bv"},   cnt_bv,   0);
    endtask

    function automatic int outs_vec();
        return 32'({Tx_Ack, Byte_Ready, Bit_Out, Bit_Valid, Tail_Zero, Scr_Init,
                    Sym_Start, Sym_Cnt, Busy, Done, Err});
    endfunction

    initial begin
        logic [7:0] v;
        Reset = 1'b0; Tx_Req = 1'b0; Rate = 4'd0; Length = 12'd0; Byte_Valid = 1'b1;
        repeat (3) @(negedge Clk);
        #1 chk("reset_outputs", outs_vec(), 0);
        Reset = 1'b1;

        // 6 Mb/s, 100 bytes: 822 bits -> 35 symbols of 24 bits
        start_frame(4'b1101, 12'd100);
        wait_done("f6m");
        check_frame("f6m", 100, 840, 35, 18, 1);

        // 54 Mb/s, 100 bytes: 4 symbols of 216 bits
        start_frame(4'b0011, 12'd100);
        wait_done("f54m");
        check_frame("f54m", 100, 864, 4, 42, 1);

        // single byte 0xA5
        a5_mode = 1'b1;
        start_frame(4'b1101, 12'd1);
        wait_done("fa5");
        check_frame("fa5", 1, 48, 2, 18, 1);
        for (int i = 0; i < 8; i++) v[i] = bits[16 + i];
        chk("fa5_byte_bits", 32'(v), 32'hA5);
        a5_mode = 1'b0;

        // rejected requests
        start_frame(4'b0000, 12'd100);
        check_reject("bad_rate");
        start_frame(4'b1101, 12'd0);
        check_reject("zero_len");

        // source stalls three cycles, starting on the b7 of byte 10
        start_frame(4'b1101, 12'd100);
        wait_bits(103);
        @(posedge Clk); #1 Byte_Valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Byte_Valid = 1'b1;
        wait_done("stall");
        check_frame("stall", 100, 840, 35, 18, 4);

        // asynchronous reset mid-frame
        start_frame(4'b1101, 12'd100);
        wait_bits(200);
        #2 Reset = 1'b0;
        #1 chk("abort_outputs", outs_vec(), 0);
        repeat (3) @(negedge Clk);
        #1 Reset = 1'b1;
        repeat (2) @(negedge Clk);
        #1 chk("abort_no_done", cnt_done, 0);

        // normal frame after the abort
        start_frame(4'b1101, 12'd100);
        wait_done("after");
        check_frame("after", 100, 840, 35, 18, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tx_encode_ctrl
`default_nettype wire
